conv_win_ctrl: RTL

- Sequencer for the 3x3 conv MAC unit.
- The MAC unit takes 9 signed 8-bit pixels and 9 signed 8-bit weights and produces a registered 64-bit sum one clock after its inputs.
- This block loads 9 weights, accepts a raster pixel stream, forms 3x3 windows with two line buffers, and drives the MAC unit.
- It collects the sums, applies optional ReLU, and emits one result per valid (unpadded) window position.

---
 rtl/conv_win_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/conv_win_ctrl.sv
// Sequencer for the 3x3 conv MAC: loads weights, builds 3x3 windows from a raster
// pixel stream with two line buffers, and collects/ReLUs the MAC sums.
//
// state  | meaning
// IDLE   | waiting for a start with a legal image size
// LOAD_W | capturing w_0..w_8 on wgt_valid_i
// RUN    | accepting pixels, forming and issuing windows
// DRAIN  | two cycles letting the last window's sum return
// DONE   | final result leaves, done_o pulses
module conv_win_ctrl #(
   parameter int MAX_W   = 32,
   parameter int DW      = 8,
   parameter int SUM_W   = 64,
   parameter bit RELU_EN = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [5:0]       img_w_i,
   input  logic [5:0]       img_h_i,
   input  logic             wgt_valid_i,
   input  logic [DW-1:0]    wgt_data_i,
   input  logic             pix_valid_i,
   output logic             pix_ready_o,
   input  logic [DW-1:0]    pix_data_i,
   output logic [9*DW-1:0]  win_o,
   output logic [9*DW-1:0]  wgt_o,
   output logic             win_valid_o,
   input  logic [SUM_W-1:0] conv_sum_i,
   output logic             out_valid_o,
   output logic [SUM_W-1:0] out_data_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o
);

   localparam int         AW     = (MAX_W > 1) ? $clog2(MAX_W) : 1;
   localparam logic [6:0] MAX_W7 = 7'(MAX_W);

   typedef enum logic [2:0] {IDLE, LOAD_W, RUN, DRAIN, DONE} state_t;

   state_t        state;
   logic [5:0]    w_q;
   logic [5:0]    h_q;
   logic [5:0]    col;
   logic [5:0]    row;
   logic [3:0]    wgt_cnt;
   logic          drain_cnt;
   logic          sum_valid;
   logic          accept;
   logic          cfg_ok;
   logic          last_col;
   logic          last_row;
   logic [AW-1:0] lb_addr;
   logic [DW-1:0] col_top;
   logic [DW-1:0] col_mid;
   logic [DW-1:0] lb1 [MAX_W];
   logic [DW-1:0] lb2 [MAX_W];

   assign accept   = (state == RUN) && pix_ready_o && pix_valid_i;
   assign cfg_ok   = (img_w_i >= 6'd3) && ({1'b0, img_w_i} <= MAX_W7) && (img_h_i >= 6'd3);
   assign last_col = (col == w_q - 6'd1);
   assign last_row = (row == h_q - 6'd1);
   assign lb_addr  = col[AW-1:0];
   assign col_top  = lb2[lb_addr];
   assign col_mid  = lb1[lb_addr];

   // lb1 holds row r-1 and lb2 row r-2 at each column; contents need no reset
   always_ff @(posedge clk_i) begin
      if (accept) begin
         lb2[lb_addr] <= col_mid;
         lb1[lb_addr] <= pix_data_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= IDLE;
         w_q         <= '0;
         h_q         <= '0;
         col         <= '0;
         row         <= '0;
         wgt_cnt     <= '0;
         drain_cnt   <= 1'b0;
         pix_ready_o <= 1'b0;
         win_o       <= '0;
         wgt_o       <= '0;
         win_valid_o <= 1'b0;
         sum_valid   <= 1'b0;
         out_valid_o <= 1'b0;
         out_data_o  <= '0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         err_o       <= 1'b0;
      end else begin
         err_o       <= 1'b0;
         done_o      <= 1'b0;
         win_valid_o <= 1'b0;
         sum_valid   <= win_valid_o;
         out_valid_o <= sum_valid;
         if (sum_valid) begin
            out_data_o <= (RELU_EN && conv_sum_i[SUM_W-1]) ? '0 : conv_sum_i;
         end

         // window shifts left one column per accepted pixel; new column enters at the right
         if (accept) begin
            for (int k = 0; k < 3; k++) begin
               win_o[DW*(3*k)   +: DW] <= win_o[DW*(3*k+1) +: DW];
               win_o[DW*(3*k+1) +: DW] <= win_o[DW*(3*k+2) +: DW];
            end
            win_o[DW*2 +: DW] <= col_top;
            win_o[DW*5 +: DW] <= col_mid;
            win_o[DW*8 +: DW] <= pix_data_i;
            win_valid_o       <= (row >= 6'd2) && (col >= 6'd2);
            if (last_col) begin
               col <= '0;
               row <= row + 6'd1;
            end else begin
               col <= col + 6'd1;
            end
         end

         case (state)
            IDLE: begin
               if (start_i) begin
                  if (cfg_ok) begin
                     w_q     <= img_w_i;
                     h_q     <= img_h_i;
                     wgt_cnt <= '0;
                     busy_o  <= 1'b1;
                     state   <= LOAD_W;
                  end else begin
                     err_o <= 1'b1;
                  end
               end
            end
            LOAD_W: begin
               if (wgt_valid_i) begin
                  for (int i = 0; i < 9; i++) begin
                     if (wgt_cnt == 4'(i)) wgt_o[DW*i +: DW] <= wgt_data_i;
                  end
                  if (wgt_cnt == 4'd8) begin
                     pix_ready_o <= 1'b1;
                     col         <= '0;
                     row         <= '0;
                     state       <= RUN;
                  end else begin
                     wgt_cnt <= wgt_cnt + 4'd1;
                  end
               end
            end
            RUN: begin
               if (accept && last_col && last_row) begin
                  pix_ready_o <= 1'b0;
                  drain_cnt   <= 1'b1;
                  state       <= DRAIN;
               end
            end
            DRAIN: begin
               if (drain_cnt == 1'b0) begin
                  done_o <= 1'b1;
                  state  <= DONE;
               end else begin
                  drain_cnt <= 1'b0;
               end
            end
            DONE: begin
               busy_o <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
